bcd_seg_driver: RTL



---
 rtl/seg_pkg.sv | 23 ++
 rtl/nibble_to_seg.sv | 14 +
 rtl/bcd_seg_driver.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display driver.
package seg_pkg;

    // Controller states: wait for a request, run double-dabble, render digits.
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        RENDER
    } state_t;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    // Nibble to glyph table: 0-9 then A, b, C, d, E, F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/nibble_to_seg.sv
// Combinational 4-bit to active-low seven-segment decoder.
module nibble_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Straight table lookup; hex glyphs cover every nibble value.
    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/bcd_seg_driver.sv
// Multi-digit seven-segment driver: sequential double-dabble conversion
// (or direct hex), leading-zero blanking, sign placement and overflow.
module bcd_seg_driver
    import seg_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    input  logic                  mode_hex,
    input  logic                  signed_mode,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [DIGITS*7-1:0]   seg
);

    localparam int BCDW = DIGITS * 4;
    localparam int EXTW = (WIDTH > BCDW) ? WIDTH : BCDW;
    localparam int CNTW = $clog2(WIDTH);

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  bin;
    logic [BCDW-1:0]   bcd;
    logic [BCDW-1:0]   adj;
    logic [CNTW-1:0]   cnt;
    logic              neg;
    logic              ovf;
    logic              blank_r;

    logic              load_neg;
    logic [WIDTH-1:0]  load_mag;
    logic [EXTW-1:0]   hex_ext;
    logic              hex_ovf;

    logic [6:0]        dec_seg [DIGITS];
    logic [DIGITS*7-1:0] seg_next;
    logic              ovf_final;
    logic              sign_ovf;
    int                msd;
    int                minus_pos;

    // One decoder per digit, fed straight from the BCD/hex nibble register.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        nibble_to_seg u_dec (
            .nibble (bcd[4*g +: 4]),
            .seg    (dec_seg[g])
        );
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: hex skips the shift phase entirely.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = mode_hex ? RENDER : SHIFT;
            SHIFT:   if (cnt == '0) state_next = RENDER;
            RENDER:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand preparation: magnitude for signed decimal, raw bits for hex.
    always_comb begin
        load_neg = signed_mode && value[WIDTH-1];
        load_mag = load_neg ? (~value + 1'b1) : value;
        hex_ext  = EXTW'(value);
        hex_ovf  = |(hex_ext >> BCDW);
    end

    // Add-3 correction applied to every BCD digit before each shift.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Digit rendering: blanking, minus placement and overflow fill.
    always_comb begin
        msd = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) msd = i;
        end
        minus_pos = blank_r ? (msd + 1) : (DIGITS - 1);
        sign_ovf  = neg && (minus_pos >= DIGITS);
        for (int i = 0; i < DIGITS; i++) begin
            if (neg && (i == minus_pos) && (bcd[4*i +: 4] != 4'd0)) sign_ovf = 1'b1;
        end
        ovf_final = ovf | sign_ovf;
        seg_next  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf_final)                  seg_next[7*i +: 7] = SEG_MINUS;
            else if (neg && i == minus_pos) seg_next[7*i +: 7] = SEG_MINUS;
            else if (blank_r && i > msd)    seg_next[7*i +: 7] = SEG_BLANK;
            else                            seg_next[7*i +: 7] = dec_seg[i];
        end
    end

    // Datapath: operand latch, shift-add-3 steps, and the output register
    // that only updates on the done edge so the display never flickers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            ovf      <= 1'b0;
            blank_r  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            seg      <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        blank_r <= blank_lz;
                        cnt     <= CNTW'(WIDTH - 1);
                        if (mode_hex) begin
                            bin <= '0;
                            bcd <= hex_ext[BCDW-1:0];
                            ovf <= hex_ovf;
                            neg <= 1'b0;
                        end else begin
                            bin <= load_mag;
                            bcd <= '0;
                            ovf <= 1'b0;
                            neg <= load_neg;
                        end
                    end
                end
                SHIFT: begin
                    bcd <= {adj[BCDW-2:0], bin[WIDTH-1]};
                    bin <= {bin[WIDTH-2:0], 1'b0};
                    ovf <= ovf | adj[BCDW-1];
                    cnt <= cnt - 1'b1;
                end
                RENDER: begin
                    seg      <= seg_next;
                    overflow <= ovf_final;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
